// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants for the UART command parser: protocol bytes, field widths,
// FSM state encoding and small helpers used by the parser datapath.
package uart_cmd_parser_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  localparam int FREQ_W = 7;
  localparam int AMP_W  = 4;
  localparam int TYPE_W = 2;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_GET_F = 3'd1;
  localparam logic [STATE_W-1:0] ST_GET_A = 3'd2;
  localparam logic [STATE_W-1:0] ST_GET_T = 3'd3;
  localparam logic [STATE_W-1:0] ST_GET_C = 3'd4;
  localparam logic [STATE_W-1:0] ST_CHECK = 3'd5;
  localparam logic [STATE_W-1:0] ST_RESP  = 3'd6;

  // Checksum plus range checks on every field of the packet.
  function automatic logic packet_ok(input logic [7:0] f, input logic [7:0] a,
                                     input logic [7:0] t, input logic [7:0] c,
                                     input logic [FREQ_W-1:0] max_freq);
    logic sum_ok;
    logic f_ok;
    sum_ok = (c == (f ^ a ^ t));
    f_ok   = !f[7] && (f[6:0] != '0) && (f[6:0] <= max_freq);
    return sum_ok && f_ok && (a[7:4] == 4'd0) && (t[7:2] == 6'd0);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte idle timer: counts while enabled, restarts on clear, and flags
// expiry in the cycle the count reaches TIMEOUT_CYCLES-1.
module cmd_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Holding the count at zero while disabled means every packet starts fresh.
  always_ff @(posedge clk) begin
    if (reset || i_clear || !i_enable) begin
      r_count <= '0;
    end else if (r_count != LAST) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command packets from the UART RX stream, validates them,
// latches generator settings and answers with ACK/NAK over TX.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int                 CLK_HZ         = 50_000_000,
  parameter int                 TIMEOUT_CYCLES = 500_000,
  parameter logic [FREQ_W-1:0]  DEF_FREQ       = 7'd10,
  parameter logic [AMP_W-1:0]   DEF_AMP        = 4'd8,
  parameter logic [TYPE_W-1:0]  DEF_TYPE       = 2'd0,
  parameter logic [FREQ_W-1:0]  MAX_FREQ       = 7'd100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic [FREQ_W-1:0] Frequency,
  output logic [AMP_W-1:0]  Amplitude,
  output logic [TYPE_W-1:0] Wave_type,
  output logic              change_command,
  output logic [7:0]        err_count
);

  if (TIMEOUT_CYCLES < 2 || CLK_HZ < 1) begin : g_bad_cfg
    $error("uart_cmd_parser: TIMEOUT_CYCLES must be >= 2 and CLK_HZ positive");
  end

  logic [STATE_W-1:0] r_state;
  logic [7:0]         r_f, r_a, r_t, r_c;
  logic [7:0]         r_resp;
  logic [7:0]         r_tx_data;
  logic               r_tx_start;
  logic [FREQ_W-1:0]  r_freq;
  logic [AMP_W-1:0]   r_amp;
  logic [TYPE_W-1:0]  r_type;
  logic               r_change;
  logic [7:0]         r_err;

  logic w_in_packet;
  logic w_expired;
  logic w_good;

  assign w_in_packet = (r_state == ST_GET_F) || (r_state == ST_GET_A) ||
                       (r_state == ST_GET_T) || (r_state == ST_GET_C);
  assign w_good      = packet_ok(r_f, r_a, r_t, r_c, MAX_FREQ);

  cmd_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (rx_valid),
    .i_enable  (w_in_packet),
    .o_expired (w_expired)
  );

  // NOTE: payload bytes carry no reset; each is rewritten before CHECK reads it.
  always_ff @(posedge clk) begin
    if (rx_valid) begin
      case (r_state)
        ST_GET_F: r_f <= rx_data;
        ST_GET_A: r_a <= rx_data;
        ST_GET_T: r_t <= rx_data;
        ST_GET_C: r_c <= rx_data;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_resp     <= 8'd0;
      r_tx_data  <= 8'd0;
      r_tx_start <= 1'b0;
      r_freq     <= DEF_FREQ;
      r_amp      <= DEF_AMP;
      r_type     <= DEF_TYPE;
      r_change   <= 1'b0;
      r_err      <= 8'd0;
    end else begin
      // NOTE: strobes default low here so each branch only has to raise them.
      r_change   <= 1'b0;
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rx_valid && (rx_data == HDR_BYTE)) r_state <= ST_GET_F;
        end
        ST_GET_F, ST_GET_A, ST_GET_T, ST_GET_C: begin
          if (rx_valid) begin
            case (r_state)
              ST_GET_F: r_state <= ST_GET_A;
              ST_GET_A: r_state <= ST_GET_T;
              ST_GET_T: r_state <= ST_GET_C;
              default:  r_state <= ST_CHECK;
            endcase
          end else if (w_expired) begin
            r_state <= ST_IDLE;
            r_err   <= sat_inc8(r_err);
          end
        end
        ST_CHECK: begin
          if (w_good) begin
            r_freq   <= r_f[FREQ_W-1:0];
            r_amp    <= r_a[AMP_W-1:0];
            r_type   <= r_t[TYPE_W-1:0];
            r_change <= 1'b1;
            r_resp   <= ACK_BYTE;
          end else begin
            r_err    <= sat_inc8(r_err);
            r_resp   <= NAK_BYTE;
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (!tx_busy) begin
            r_tx_data  <= r_resp;
            r_tx_start <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_data        = r_tx_data;
  assign tx_start       = r_tx_start;
  assign Frequency      = r_freq;
  assign Amplitude      = r_amp;
  assign Wave_type      = r_type;
  assign change_command = r_change;
  assign err_count      = r_err;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a packet table plus hand sequences for
// timeout, busy transmitter, dropped bytes, saturation and mid-response reset.
module tb_uart_cmd_parser;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [6:0] Frequency;
  logic [3:0] Amplitude;
  logic [1:0] Wave_type;
  logic       change_command;
  logic [7:0] err_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_chg  = 0;
  int n_start = 0;

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .tx_busy        (tx_busy),
    .tx_data        (tx_data),
    .tx_start       (tx_start),
    .Frequency      (Frequency),
    .Amplitude      (Amplitude),
    .Wave_type      (Wave_type),
    .change_command (change_command),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (change_command) n_chg++;
    if (tx_start) n_start++;
  end

  typedef struct {
    logic [4:0][7:0] pkt;
    int              busy;
    logic            ack;
    logic [6:0]      f;
    logic [3:0]      a;
    logic [1:0]      t;
    logic [7:0]      err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
  endtask

  // Sends a packet and watches the response; latencies count edges from the
  // edge that captures the checksum byte (that edge is 1).
  task automatic run_packet(input logic [4:0][7:0] pkt, input int busy,
                            output int chg_n, output int chg_lat,
                            output int start_n, output int start_lat);
    for (int k = 4; k >= 1; k--) send_byte(pkt[k]);
    chg_n = 0; chg_lat = -1; start_n = 0; start_lat = -1;
    tx_busy  = (busy > 0);
    rx_data  = pkt[0];
    rx_valid = 1'b1;
    for (int i = 1; i <= busy + 12; i++) begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      if (change_command) begin
        chg_n++;
        if (chg_lat < 0) chg_lat = i;
      end
      if (tx_start) begin
        start_n++;
        if (start_lat < 0) start_lat = i;
      end
      if (i == busy) tx_busy = 1'b0;
    end
    tx_busy = 1'b0;
  endtask

  initial begin
    int cn, cl, sn, sl;
    logic [4:0][7:0] p;

    vecs[0] = '{pkt: {8'hA5, 8'h32, 8'h05, 8'h02, 8'h35}, busy: 0,    ack: 1, f: 50,  a: 5,  t: 2, err: 0};
    vecs[1] = '{pkt: {8'hA5, 8'h32, 8'h05, 8'h02, 8'h34}, busy: 0,    ack: 0, f: 50,  a: 5,  t: 2, err: 1};
    vecs[2] = '{pkt: {8'hA5, 8'h65, 8'h01, 8'h00, 8'h64}, busy: 0,    ack: 0, f: 50,  a: 5,  t: 2, err: 2};
    vecs[3] = '{pkt: {8'hA5, 8'h00, 8'h01, 8'h00, 8'h01}, busy: 0,    ack: 0, f: 50,  a: 5,  t: 2, err: 3};
    vecs[4] = '{pkt: {8'hA5, 8'h0A, 8'h0F, 8'h03, 8'h06}, busy: 1000, ack: 1, f: 10,  a: 15, t: 3, err: 3};
    vecs[5] = '{pkt: {8'hA5, 8'h64, 8'h00, 8'h01, 8'h65}, busy: 3,    ack: 1, f: 100, a: 0,  t: 1, err: 3};
    vecs[6] = '{pkt: {8'hA5, 8'h01, 8'h10, 8'h00, 8'h11}, busy: 0,    ack: 0, f: 100, a: 0,  t: 1, err: 4};
    vecs[7] = '{pkt: {8'hA5, 8'h05, 8'h01, 8'h04, 8'h00}, busy: 0,    ack: 0, f: 100, a: 0,  t: 1, err: 5};
    vecs[8] = '{pkt: {8'hA5, 8'h10, 8'h02, 8'h01, 8'hA5}, busy: 0,    ack: 0, f: 100, a: 0,  t: 1, err: 6};

    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_busy = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    n_chg = 0; n_start = 0;
    repeat (20) tick();
    check("reset_freq", Frequency, 10);
    check("reset_amp", Amplitude, 8);
    check("reset_type", Wave_type, 0);
    check("reset_err", err_count, 0);
    check("reset_txdata", tx_data, 0);
    check("reset_no_chg", n_chg, 0);
    check("reset_no_start", n_start, 0);

    send_byte(8'h11);
    send_byte(8'h32);

    foreach (vecs[v]) begin
      run_packet(vecs[v].pkt, vecs[v].busy, cn, cl, sn, sl);
      check($sformatf("v%0d_freq", v), Frequency, vecs[v].f);
      check($sformatf("v%0d_amp", v), Amplitude, vecs[v].a);
      check($sformatf("v%0d_type", v), Wave_type, vecs[v].t);
      check($sformatf("v%0d_err", v), err_count, vecs[v].err);
      check($sformatf("v%0d_txdata", v), tx_data, vecs[v].ack ? 8'h06 : 8'h15);
      check($sformatf("v%0d_chg_n", v), cn, vecs[v].ack ? 1 : 0);
      if (vecs[v].ack) check($sformatf("v%0d_chg_lat", v), cl, 2);
      check($sformatf("v%0d_start_n", v), sn, 1);
      check($sformatf("v%0d_start_lat", v), sl, ((vecs[v].busy > 2) ? vecs[v].busy : 2) + 1);
    end

    n_chg = 0; n_start = 0;
    send_byte(8'hA5);
    rx_data = 8'h32; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (TO - 1) tick();
    check("to_err_before", err_count, 6);
    tick();
    check("to_err_after", err_count, 7);
    repeat (5) tick();
    check("to_no_chg", n_chg, 0);
    check("to_no_start", n_start, 0);
    p = {8'hA5, 8'h14, 8'h03, 8'h01, 8'h16};
    run_packet(p, 0, cn, cl, sn, sl);
    check("to_next_chg", cn, 1);
    check("to_next_freq", Frequency, 20);
    check("to_next_amp", Amplitude, 3);
    check("to_next_type", Wave_type, 1);
    check("to_next_txdata", tx_data, 8'h06);
    check("to_next_err", err_count, 7);

    send_byte(8'hA5); send_byte(8'h32); send_byte(8'h05); send_byte(8'h02);
    tx_busy = 1'b1;
    send_byte(8'h35);
    send_byte(8'hA5);
    n_chg = 0; n_start = 0;
    tx_busy = 1'b0;
    repeat (3) tick();
    check("drop_start", n_start, 1);
    n_chg = 0; n_start = 0;
    send_byte(8'h32); send_byte(8'h05); send_byte(8'h02); send_byte(8'h35);
    repeat (5) tick();
    check("drop_no_chg", n_chg, 0);
    check("drop_no_start", n_start, 0);
    check("drop_freq", Frequency, 50);

    p = {8'hA5, 8'h32, 8'h05, 8'h02, 8'h34};
    for (int n = 0; n < 250; n++) run_packet(p, 0, cn, cl, sn, sl);
    check("sat_below", err_count, 255);
    run_packet(p, 0, cn, cl, sn, sl);
    check("sat_hold", err_count, 255);
    check("sat_nak", tx_data, 8'h15);

    send_byte(8'hA5); send_byte(8'h0A); send_byte(8'h0F); send_byte(8'h03);
    tx_busy = 1'b1;
    send_byte(8'h06);
    repeat (5) tick();
    n_start = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_freq", Frequency, 10);
    check("rst_amp", Amplitude, 8);
    check("rst_type", Wave_type, 0);
    check("rst_err", err_count, 0);
    check("rst_txdata", tx_data, 0);
    check("rst_chg", change_command, 0);
    tx_busy = 1'b0;
    repeat (20) tick();
    check("rst_no_start", n_start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
